// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 cores.
// Contents: opcode constants, FSM state enum, ALU control codes and the
// instruction-class enum produced by legv8_decode.
package legv8_pkg;

    // Full 11-bit opcodes (IR[31:21])
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Prefix opcodes: CB uses IR[31:24], B uses IR[31:26]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [3:0]  ALU_AND = 4'b0000;
    localparam logic [3:0]  ALU_ORR = 4'b0001;
    localparam logic [3:0]  ALU_ADD = 4'b0010;
    localparam logic [3:0]  ALU_SUB = 4'b0110;

    localparam logic [4:0]  XZR     = 5'd31;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_D_LD,
        CL_D_ST,
        CL_CB_Z,
        CL_CB_NZ,
        CL_B,
        CL_ILL
    } iclass_t;

endpackage

// File: rtl/legv8_decode.sv
// Combinational LEGv8 instruction decoder.
// Ports:
//   ir      - instruction word
//   iclass  - instruction class (CL_ILL for unrecognised opcodes)
//   rn      - first source index  (IR[9:5])
//   rm      - second source index (IR[20:16] for R-type, else IR[4:0])
//   rd      - destination index   (IR[4:0])
//   imm     - sign-extended immediate, already shifted for CB/B
//   alu_ctl - ALU control code
module legv8_decode
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [31:0]       ir,
    output iclass_t           iclass,
    output logic [4:0]        rn,
    output logic [4:0]        rm,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] imm,
    output logic [3:0]        alu_ctl
);

    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] imm_cb;
    logic [DATA_W-1:0] imm_b;

    assign imm_d  = {{(DATA_W-9){ir[20]}}, ir[20:12]};
    assign imm_cb = {{(DATA_W-21){ir[23]}}, ir[23:5], 2'b00};
    assign imm_b  = {{(DATA_W-28){ir[25]}}, ir[25:0], 2'b00};

    always_comb begin
        iclass  = CL_ILL;
        alu_ctl = ALU_ADD;
        imm     = '0;
        rn      = ir[9:5];
        rd      = ir[4:0];
        rm      = ir[4:0];
        if (ir[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            iclass = CL_R;
            rm     = ir[20:16];
            case (ir[31:21])
                OP_SUB:  alu_ctl = ALU_SUB;
                OP_AND:  alu_ctl = ALU_AND;
                OP_ORR:  alu_ctl = ALU_ORR;
                default: alu_ctl = ALU_ADD;
            endcase
        end else if (ir[31:21] == OP_LDUR) begin
            iclass = CL_D_LD;
            imm    = imm_d;
        end else if (ir[31:21] == OP_STUR) begin
            iclass = CL_D_ST;
            imm    = imm_d;
        end else if (ir[31:24] == OP_CBZ) begin
            iclass = CL_CB_Z;
            imm    = imm_cb;
        end else if (ir[31:24] == OP_CBNZ) begin
            iclass = CL_CB_NZ;
            imm    = imm_cb;
        end else if (ir[31:26] == OP_B) begin
            iclass = CL_B;
            imm    = imm_b;
        end
    end

endmodule

// File: rtl/cpu_mc_legv8.sv
// Multi-cycle LEGv8 core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   CLOCK/RESET           - clock, synchronous active-high reset
//   IMEM_*                - instruction fetch handshake (REQ held until VALID)
//   DMEM_*                - data load/store handshake (REQ held until VALID)
//   READ_REG_*/REG_DATA*  - external register file read ports
//   REGWRITE/WRITE_REG*   - external register file write port
//   PC                    - current PC
//   RETIRE/RETIRE_CNT     - retire pulse and wrapping retire counter
//   HALTED                - stopped on an illegal opcode until RESET
module cpu_mc_legv8
    import legv8_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_VALID,
    input  logic [31:0]       IMEM_RDATA,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [ADDR_W-1:0] DMEM_ADDR,
    output logic [DATA_W-1:0] DMEM_WDATA,
    input  logic              DMEM_VALID,
    input  logic [DATA_W-1:0] DMEM_RDATA,
    output logic [4:0]        READ_REG_1,
    output logic [4:0]        READ_REG_2,
    input  logic [DATA_W-1:0] REG_DATA1,
    input  logic [DATA_W-1:0] REG_DATA2,
    output logic              REGWRITE,
    output logic [4:0]        WRITE_REG,
    output logic [DATA_W-1:0] WRITE_REG_DATA,
    output logic [ADDR_W-1:0] PC,
    output logic              RETIRE,
    output logic [CNT_W-1:0]  RETIRE_CNT,
    output logic              HALTED
);

    state_t            state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    iclass_t           iclass;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_ctl;

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_y;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_branch;
    logic              taken;

    legv8_decode #(.DATA_W(DATA_W)) u_decode (
        .ir      (ir),
        .iclass  (iclass),
        .rn      (rn),
        .rm      (rm),
        .rd      (rd),
        .imm     (imm),
        .alu_ctl (alu_ctl)
    );

    assign IMEM_ADDR  = PC;
    assign READ_REG_1 = rn;
    assign READ_REG_2 = rm;

    assign pc_seq    = PC + ADDR_W'(4);
    assign pc_branch = PC + imm[ADDR_W-1:0];
    assign taken     = (iclass == CL_CB_Z) ? (b_q == '0) : (b_q != '0);

    always_comb begin
        op_b = (iclass == CL_R) ? b_q : imm;
        case (alu_ctl)
            ALU_AND: alu_y = a_q & op_b;
            ALU_ORR: alu_y = a_q | op_b;
            ALU_SUB: alu_y = a_q - op_b;
            default: alu_y = a_q + op_b;
        endcase
    end

    // IMEM_REQ is registered: it is raised one cycle after reset leaves the
    // core in FETCH, and re-raised together with RETIRE so back-to-back
    // instructions need no idle cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state          <= ST_FETCH;
            PC             <= RESET_PC;
            ir             <= '0;
            a_q            <= '0;
            b_q            <= '0;
            IMEM_REQ       <= 1'b0;
            DMEM_REQ       <= 1'b0;
            DMEM_WE        <= 1'b0;
            DMEM_ADDR      <= '0;
            DMEM_WDATA     <= '0;
            REGWRITE       <= 1'b0;
            WRITE_REG      <= '0;
            WRITE_REG_DATA <= '0;
            RETIRE         <= 1'b0;
            RETIRE_CNT     <= '0;
            HALTED         <= 1'b0;
        end else begin
            RETIRE   <= 1'b0;
            REGWRITE <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (!IMEM_REQ) begin
                        IMEM_REQ <= 1'b1;
                    end else if (IMEM_VALID) begin
                        ir       <= IMEM_RDATA;
                        IMEM_REQ <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (iclass == CL_ILL) begin
                        HALTED <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        a_q   <= (rn == XZR) ? '0 : REG_DATA1;
                        b_q   <= (rm == XZR) ? '0 : REG_DATA2;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (iclass)
                        CL_B, CL_CB_Z, CL_CB_NZ: begin
                            PC         <= (iclass == CL_B || taken) ? pc_branch : pc_seq;
                            RETIRE     <= 1'b1;
                            RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
                            IMEM_REQ   <= 1'b1;
                            state      <= ST_FETCH;
                        end
                        CL_R: begin
                            WRITE_REG      <= rd;
                            WRITE_REG_DATA <= alu_y;
                            REGWRITE       <= (rd != XZR);
                            state          <= ST_WB;
                        end
                        CL_D_LD, CL_D_ST: begin
                            DMEM_REQ   <= 1'b1;
                            DMEM_WE    <= (iclass == CL_D_ST);
                            DMEM_ADDR  <= alu_y[ADDR_W-1:0];
                            DMEM_WDATA <= b_q;
                            state      <= ST_MEM;
                        end
                        default: begin
                            HALTED <= 1'b1;
                            state  <= ST_HALT;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (DMEM_VALID) begin
                        DMEM_REQ <= 1'b0;
                        DMEM_WE  <= 1'b0;
                        if (iclass == CL_D_ST) begin
                            PC         <= pc_seq;
                            RETIRE     <= 1'b1;
                            RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
                            IMEM_REQ   <= 1'b1;
                            state      <= ST_FETCH;
                        end else begin
                            // WRITE_REG_DATA doubles as the MDR for loads
                            WRITE_REG      <= rd;
                            WRITE_REG_DATA <= DMEM_RDATA;
                            REGWRITE       <= (rd != XZR);
                            state          <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    PC         <= pc_seq;
                    RETIRE     <= 1'b1;
                    RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
                    IMEM_REQ   <= 1'b1;
                    state      <= ST_FETCH;
                end
                default: begin
                    // HALT: absorbing until RESET
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc_legv8.sv
// Self-checking bench for cpu_mc_legv8: memory/regfile responders plus a
// plain-arithmetic reference model of the LEGv8 subset.
module tb_cpu_mc_legv8;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        IMEM_REQ, IMEM_VALID;
    logic [63:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        DMEM_REQ, DMEM_WE, DMEM_VALID;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [4:0]  READ_REG_1, READ_REG_2, WRITE_REG;
    logic [63:0] REG_DATA1, REG_DATA2, WRITE_REG_DATA, PC;
    logic        REGWRITE, RETIRE, HALTED;
    logic [31:0] RETIRE_CNT;

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem     [bit [63:0]];
    int          imem_lat [bit [63:0]];
    logic [63:0] dmem     [bit [63:0]];
    logic [63:0] rf       [32];
    int          dmem_wait = 0;
    int          imem_cnt  = 0;
    int          dmem_cnt  = 0;

    typedef struct {
        int          cyc;
        logic        wrote;
        logic [4:0]  wreg;
        logic [63:0] wdata;
        logic        saw_mem;
        logic        m_we;
        logic [63:0] m_addr;
        logic [63:0] m_wdata;
        logic        m_stable;
        logic [63:0] pc;
        logic        timeout;
    } run_t;

    always #5 CLOCK = ~CLOCK;

    cpu_mc_legv8 #(
        .DATA_W   (64),
        .ADDR_W   (64),
        .RESET_PC (64'h0),
        .CNT_W    (32)
    ) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .IMEM_REQ       (IMEM_REQ),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_VALID     (IMEM_VALID),
        .IMEM_RDATA     (IMEM_RDATA),
        .DMEM_REQ       (DMEM_REQ),
        .DMEM_WE        (DMEM_WE),
        .DMEM_ADDR      (DMEM_ADDR),
        .DMEM_WDATA     (DMEM_WDATA),
        .DMEM_VALID     (DMEM_VALID),
        .DMEM_RDATA     (DMEM_RDATA),
        .READ_REG_1     (READ_REG_1),
        .READ_REG_2     (READ_REG_2),
        .REG_DATA1      (REG_DATA1),
        .REG_DATA2      (REG_DATA2),
        .REGWRITE       (REGWRITE),
        .WRITE_REG      (WRITE_REG),
        .WRITE_REG_DATA (WRITE_REG_DATA),
        .PC             (PC),
        .RETIRE         (RETIRE),
        .RETIRE_CNT     (RETIRE_CNT),
        .HALTED         (HALTED)
    );

    assign REG_DATA1 = rf[READ_REG_1];
    assign REG_DATA2 = rf[READ_REG_2];

    // Instruction memory: per-address latency, random junk when idle.
    always @(negedge CLOCK) begin
        if (IMEM_REQ) begin
            if (imem_cnt >= (imem_lat.exists(IMEM_ADDR) ? imem_lat[IMEM_ADDR] : 0)) begin
                IMEM_VALID = 1'b1;
                IMEM_RDATA = imem.exists(IMEM_ADDR) ? imem[IMEM_ADDR] : 32'h0;
            end else begin
                IMEM_VALID = 1'b0;
                IMEM_RDATA = $urandom;
            end
            imem_cnt++;
        end else begin
            imem_cnt   = 0;
            IMEM_VALID = 1'($urandom_range(0, 1));
            IMEM_RDATA = $urandom;
        end
    end

    // Data memory: fixed wait count, store committed on the accepting cycle.
    always @(negedge CLOCK) begin
        if (DMEM_REQ) begin
            if (dmem_cnt >= dmem_wait) begin
                DMEM_VALID = 1'b1;
                if (DMEM_WE) dmem[DMEM_ADDR] = DMEM_WDATA;
                DMEM_RDATA = dmem.exists(DMEM_ADDR) ? dmem[DMEM_ADDR] : 64'h0;
            end else begin
                DMEM_VALID = 1'b0;
                DMEM_RDATA = {$urandom, $urandom};
            end
            dmem_cnt++;
        end else begin
            dmem_cnt   = 0;
            DMEM_VALID = 1'($urandom_range(0, 1));
            DMEM_RDATA = {$urandom, $urandom};
        end
    end

    function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
        return {op, rm, 6'b0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(logic nz, logic [18:0] imm, logic [4:0] rt);
        return {7'b1011010, nz, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    localparam logic [10:0] T_ADD = 11'b10001011000;
    localparam logic [10:0] T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000;
    localparam logic [10:0] T_ORR = 11'b10101010000;
    localparam logic [10:0] T_LDR = 11'b11111000010;
    localparam logic [10:0] T_STR = 11'b11111000000;

    task automatic clear_prog();
        imem.delete();
        imem_lat.delete();
        dmem_wait = 0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        for (int i = 0; i < 5 && !IMEM_REQ; i++) @(negedge CLOCK);
    endtask

    // Starts on a negedge inside FETCH; returns on the negedge where RETIRE is seen.
    task automatic run_instr(output run_t r);
        r.cyc = 0; r.wrote = 1'b0; r.wreg = '0; r.wdata = '0; r.saw_mem = 1'b0;
        r.m_we = 1'b0; r.m_addr = '0; r.m_wdata = '0; r.m_stable = 1'b1;
        r.pc = '0; r.timeout = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK);
            r.cyc++;
            if (DMEM_REQ) begin
                if (!r.saw_mem) begin
                    r.saw_mem = 1'b1; r.m_we = DMEM_WE; r.m_addr = DMEM_ADDR; r.m_wdata = DMEM_WDATA;
                end else if (DMEM_ADDR !== r.m_addr || DMEM_WE !== r.m_we || DMEM_WDATA !== r.m_wdata) begin
                    r.m_stable = 1'b0;
                end
            end
            if (REGWRITE) begin
                r.wrote = 1'b1; r.wreg = WRITE_REG; r.wdata = WRITE_REG_DATA;
                rf[WRITE_REG] = WRITE_REG_DATA;
            end
            if (RETIRE) begin
                r.timeout = 1'b0;
                r.pc = PC;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        checks++; if (PC !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC); end
        checks++; if (RETIRE_CNT !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", RETIRE_CNT); end
        checks++;
        if ({IMEM_REQ, DMEM_REQ, DMEM_WE, REGWRITE, RETIRE, HALTED} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {IMEM_REQ, DMEM_REQ, DMEM_WE, REGWRITE, RETIRE, HALTED});
        end
        RESET = 1'b0;
        @(negedge CLOCK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0) begin
            failures++; $display("FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=0", IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_rtype_program();
        run_t r;
        int total;
        logic [63:0] exp_d [4] = '{64'd12, 64'd2, 64'd7, 64'd5};
        clear_prog();
        rf[1] = 64'd7; rf[2] = 64'd5;
        imem[64'h0] = enc_r(T_ADD, 5'd2, 5'd1, 5'd3);
        imem[64'h4] = enc_r(T_SUB, 5'd2, 5'd1, 5'd4);
        imem[64'h8] = enc_r(T_ORR, 5'd2, 5'd1, 5'd5);
        imem[64'hC] = enc_r(T_AND, 5'd2, 5'd1, 5'd6);
        do_reset();
        total = 0;
        for (int k = 0; k < 4; k++) begin
            run_instr(r);
            total += r.cyc;
            checks++;
            if (!r.wrote || r.wreg !== 5'(3 + k) || r.wdata !== exp_d[k]) begin
                failures++;
                $display("FAIL rtype_%0d wrote=%b reg=%0d data=%0d exp reg=%0d data=%0d", k, r.wrote, r.wreg, r.wdata, 3 + k, exp_d[k]);
            end
            checks++; if (r.cyc != 4) begin failures++; $display("FAIL rtype_cycles_%0d got=%0d exp=4", k, r.cyc); end
        end
        checks++; if (total != 16) begin failures++; $display("FAIL rtype_total got=%0d exp=16", total); end
        checks++; if (RETIRE_CNT !== 32'd4) begin failures++; $display("FAIL rtype_retire_cnt got=%0d exp=4", RETIRE_CNT); end
        checks++; if (PC !== 64'h10) begin failures++; $display("FAIL rtype_pc got=%h exp=10", PC); end
    endtask

    task automatic test_load_store();
        run_t r;
        clear_prog();
        rf[0] = 64'h100; rf[1] = 64'd7;
        imem[64'h0] = enc_d(T_STR, 9'd8, 5'd0, 5'd1);
        imem[64'h4] = enc_d(T_LDR, 9'd8, 5'd0, 5'd9);
        imem[64'h8] = enc_d(T_LDR, 9'd8, 5'd0, 5'd10);
        imem[64'hC] = enc_d(T_STR, 9'h1F8, 5'd0, 5'd1);
        do_reset();
        run_instr(r);
        checks++;
        if (!r.saw_mem || r.m_addr !== 64'h108 || r.m_we !== 1'b1 || r.m_wdata !== 64'd7) begin
            failures++; $display("FAIL stur_access addr=%h we=%b wdata=%h exp addr=108 we=1 wdata=7", r.m_addr, r.m_we, r.m_wdata);
        end
        checks++; if (r.cyc != 4 || r.wrote) begin failures++; $display("FAIL stur_cycles got=%0d wrote=%b exp=4 wrote=0", r.cyc, r.wrote); end
        run_instr(r);
        checks++;
        if (r.m_we !== 1'b0 || r.wreg !== 5'd9 || r.wdata !== 64'd7 || !r.wrote) begin
            failures++; $display("FAIL ldur_data we=%b reg=%0d data=%h exp we=0 reg=9 data=7", r.m_we, r.wreg, r.wdata);
        end
        checks++; if (r.cyc != 5) begin failures++; $display("FAIL ldur_cycles got=%0d exp=5", r.cyc); end
        dmem_wait = 3;
        run_instr(r);
        checks++; if (r.cyc != 8) begin failures++; $display("FAIL ldur_wait_cycles got=%0d exp=8", r.cyc); end
        checks++;
        if (!r.m_stable || r.m_addr !== 64'h108 || r.wdata !== 64'd7 || r.wreg !== 5'd10) begin
            failures++; $display("FAIL ldur_wait_hold stable=%b addr=%h data=%h reg=%0d exp stable=1 addr=108 data=7 reg=10", r.m_stable, r.m_addr, r.wdata, r.wreg);
        end
        dmem_wait = 0;
        run_instr(r);
        checks++; if (r.m_addr !== 64'hF8) begin failures++; $display("FAIL stur_neg_offset got=%h exp=f8", r.m_addr); end
    endtask

    task automatic test_branches();
        run_t r;
        logic [31:0] br_ins [3];
        logic [63:0] br_pc  [3] = '{64'h3C, 64'h44, 64'h3C};
        br_ins[0] = enc_cb(1'b0, 19'h7FFFF, 5'd31);
        br_ins[1] = enc_cb(1'b1, 19'h7FFFF, 5'd31);
        br_ins[2] = enc_b(26'h3FFFFFF);
        rf[31] = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            clear_prog();
            imem[64'h0]  = enc_b(26'd16);
            imem[64'h40] = br_ins[k];
            do_reset();
            run_instr(r);
            checks++; if (r.pc !== 64'h40 || r.cyc != 3) begin failures++; $display("FAIL b_to_40 pc=%h cyc=%0d exp pc=40 cyc=3", r.pc, r.cyc); end
            run_instr(r);
            checks++;
            if (r.pc !== br_pc[k] || r.cyc != 3) begin
                failures++; $display("FAIL branch_%0d pc=%h cyc=%0d exp pc=%h cyc=3", k, r.pc, r.cyc, br_pc[k]);
            end
        end
        // randomized CBZ/CBNZ against the taken/not-taken rule
        for (int k = 0; k < 8; k++) begin
            logic [4:0]  rt;
            logic [18:0] imm19;
            logic        nz, is_taken;
            logic [63:0] v, exp_pc;
            longint      off;
            rt    = 5'($urandom_range(0, 30));
            imm19 = 19'($urandom);
            nz    = 1'($urandom_range(0, 1));
            v     = ($urandom_range(0, 1) != 0) ? 64'h0 : ({$urandom, $urandom} | 64'h1);
            rf[rt] = v;
            is_taken = nz ? (v != 0) : (v == 0);
            off    = longint'($signed(imm19)) * 4;
            exp_pc = is_taken ? 64'h40 + 64'(off) : 64'h44;
            clear_prog();
            imem[64'h0]  = enc_b(26'd16);
            imem[64'h40] = enc_cb(nz, imm19, rt);
            do_reset();
            run_instr(r);
            run_instr(r);
            checks++;
            if (r.pc !== exp_pc || r.cyc != 3) begin
                failures++; $display("FAIL cb_rand_%0d pc=%h cyc=%0d exp pc=%h cyc=3", k, r.pc, r.cyc, exp_pc);
            end
        end
        // PC wraps below zero
        clear_prog();
        imem[64'h0] = enc_b(26'h3FFFFFF);
        do_reset();
        run_instr(r);
        checks++; if (r.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL pc_wrap got=%h exp=fffffffffffffffc", r.pc); end
    endtask

    task automatic test_xzr();
        run_t r;
        clear_prog();
        rf[1] = 64'd7; rf[2] = 64'd5; rf[31] = 64'hDEAD;
        imem[64'h0] = enc_r(T_ADD, 5'd2, 5'd1, 5'd31);
        imem[64'h4] = enc_r(T_ADD, 5'd1, 5'd31, 5'd7);
        imem[64'h8] = enc_r(T_ORR, 5'd31, 5'd2, 5'd8);
        do_reset();
        run_instr(r);
        checks++;
        if (r.wrote || r.timeout || r.cyc != 4 || RETIRE_CNT !== 32'd1) begin
            failures++; $display("FAIL xzr_dest wrote=%b cyc=%0d cnt=%0d exp wrote=0 cyc=4 cnt=1", r.wrote, r.cyc, RETIRE_CNT);
        end
        run_instr(r);
        checks++; if (r.wdata !== 64'd7 || r.wreg !== 5'd7) begin failures++; $display("FAIL xzr_read_a data=%h exp=7", r.wdata); end
        run_instr(r);
        checks++; if (r.wdata !== 64'd5 || r.wreg !== 5'd8) begin failures++; $display("FAIL xzr_read_b data=%h exp=5", r.wdata); end
    endtask

    task automatic test_random_rtype();
        run_t r;
        logic [63:0] m [32];
        logic [10:0] ops [4] = '{T_ADD, T_SUB, T_AND, T_ORR};
        int          sel [20];
        int          lat [20];
        logic [4:0]  rd_a [20];
        logic [4:0]  rn_a [20];
        logic [4:0]  rm_a [20];
        clear_prog();
        for (int i = 0; i < 32; i++) begin
            rf[i] = {$urandom, $urandom};
            m[i]  = rf[i];
        end
        for (int k = 0; k < 20; k++) begin
            sel[k]  = $urandom_range(0, 3);
            lat[k]  = $urandom_range(0, 2);
            rd_a[k] = 5'($urandom); rn_a[k] = 5'($urandom); rm_a[k] = 5'($urandom);
            imem[64'(4 * k)]     = enc_r(ops[sel[k]], rm_a[k], rn_a[k], rd_a[k]);
            imem_lat[64'(4 * k)] = lat[k];
        end
        do_reset();
        for (int k = 0; k < 20; k++) begin
            logic [63:0] a, b, res;
            a = (rn_a[k] == 5'd31) ? 64'h0 : m[rn_a[k]];
            b = (rm_a[k] == 5'd31) ? 64'h0 : m[rm_a[k]];
            case (sel[k])
                0: res = a + b;
                1: res = a - b;
                2: res = a & b;
                default: res = a | b;
            endcase
            if (rd_a[k] != 5'd31) m[rd_a[k]] = res;
            run_instr(r);
            checks++;
            if (r.wrote !== (rd_a[k] != 5'd31) || (r.wrote && (r.wreg !== rd_a[k] || r.wdata !== res))) begin
                failures++;
                $display("FAIL rand_rtype_%0d wrote=%b reg=%0d data=%h exp reg=%0d data=%h", k, r.wrote, r.wreg, r.wdata, rd_a[k], res);
            end
            checks++; if (r.cyc != 4 + lat[k]) begin failures++; $display("FAIL rand_cycles_%0d got=%0d exp=%0d", k, r.cyc, 4 + lat[k]); end
        end
    endtask

    task automatic test_reset_mid_mem();
        run_t r;
        logic got_req;
        clear_prog();
        rf[0] = 64'h100; rf[1] = 64'd7;
        imem[64'h0] = enc_r(T_ADD, 5'd1, 5'd1, 5'd3);
        imem[64'h4] = enc_d(T_STR, 9'd0, 5'd0, 5'd1);
        dmem_wait = 1000;
        do_reset();
        run_instr(r);
        got_req = 1'b0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge CLOCK);
            got_req = DMEM_REQ;
        end
        checks++; if (!got_req) begin failures++; $display("FAIL mid_mem_req got=0 exp=1"); end
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        checks++;
        if (PC !== 64'h0 || DMEM_REQ !== 1'b0 || DMEM_WE !== 1'b0 || RETIRE_CNT !== 32'd0) begin
            failures++; $display("FAIL mid_mem_reset pc=%h req=%b we=%b cnt=%0d exp pc=0 req=0 we=0 cnt=0", PC, DMEM_REQ, DMEM_WE, RETIRE_CNT);
        end
        dmem_wait = 0;
        RESET = 1'b0;
        @(negedge CLOCK);
        checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0) begin failures++; $display("FAIL mid_mem_refetch req=%b addr=%h exp req=1 addr=0", IMEM_REQ, IMEM_ADDR); end
        run_instr(r);
        checks++;
        if (r.wdata !== 64'd14 || r.cyc != 4 || RETIRE_CNT !== 32'd1) begin
            failures++; $display("FAIL mid_mem_resume data=%0d cyc=%0d cnt=%0d exp data=14 cyc=4 cnt=1", r.wdata, r.cyc, RETIRE_CNT);
        end
    endtask

    task automatic test_illegal();
        run_t r;
        int bad;
        clear_prog();
        rf[1] = 64'd7; rf[2] = 64'd5;
        imem[64'h0] = enc_r(T_ADD, 5'd2, 5'd1, 5'd3);
        imem[64'h4] = 32'h0000_0000;
        do_reset();
        run_instr(r);
        repeat (2) @(negedge CLOCK);
        checks++; if (HALTED !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", HALTED); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            if (IMEM_REQ || RETIRE || DMEM_REQ || REGWRITE || PC !== 64'h4 || !HALTED) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL halt_absorbing bad_cycles=%0d exp=0", bad); end
        checks++; if (RETIRE_CNT !== 32'd1) begin failures++; $display("FAIL halt_cnt got=%0d exp=1", RETIRE_CNT); end
        do_reset();
        checks++; if (HALTED !== 1'b0 || PC !== 64'h0) begin failures++; $display("FAIL halt_exit halted=%b pc=%h exp halted=0 pc=0", HALTED, PC); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_rtype_program();
        test_load_store();
        test_branches();
        test_xzr();
        test_random_rtype();
        test_reset_mid_mem();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_mc_legv8.md
Name: cpu_mc_legv8

Overview:
- Parametrised multi-cycle successor to the single-cycle LEGv8 core.
- One instruction runs as a sequence of FSM states: FETCH, DECODE, EXEC, MEM, WB.
- Instruction and data memories use valid/request handshakes, so wait states are tolerated. The register file stays external.
- Adds CBNZ, XZR handling, illegal-opcode halt and a retired-instruction counter.

Parameters:
- DATA_W, 64, datapath/register width (32 or 64).
- ADDR_W, 64, PC and memory address width (<= DATA_W).
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, width of RETIRE_CNT.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ADDR  out  ADDR_W  fetch address (= PC).
- IMEM_VALID  in  1  IMEM_RDATA valid this cycle.
- IMEM_RDATA  in  32  instruction word.
- DMEM_REQ  out  1  data access request.
- DMEM_WE  out  1  1 = store, 0 = load.
- DMEM_ADDR  out  ADDR_W  data address.
- DMEM_WDATA  out  DATA_W  store data.
- DMEM_VALID  in  1  access complete / DMEM_RDATA valid.
- DMEM_RDATA  in  DATA_W  load data.
- READ_REG_1  out  5  register file read index A.
- READ_REG_2  out  5  register file read index B.
- REG_DATA1  in  DATA_W  read data A.
- REG_DATA2  in  DATA_W  read data B.
- REGWRITE  out  1  write enable, one cycle.
- WRITE_REG  out  5  write index.
- WRITE_REG_DATA  out  DATA_W  write data.
- PC  out  ADDR_W  current PC.
- RETIRE  out  1  one-cycle pulse per completed instruction.
- RETIRE_CNT  out  CNT_W  retired-instruction count.
- HALTED  out  1  core stopped on an illegal opcode.

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH, PC = RESET_PC, IR = 0, RETIRE_CNT = 0.
  - All REQ/WE/REGWRITE/RETIRE/HALTED = 0.
  - Reset wins over every other event, including mid-handshake. An outstanding memory response after reset is ignored.
- FETCH:
  - IMEM_REQ = 1 and IMEM_ADDR = PC, held stable until IMEM_VALID.
  - On the edge where IMEM_VALID = 1: latch IR, go to DECODE.
  - IMEM_VALID without a request is ignored.
- DECODE:
  - READ_REG_1 = IR[9:5].
  - READ_REG_2 = IR[20:16] for R-type, else IR[4:0].
  - Latch A and B. An index of 31 reads as 0 (XZR) regardless of REG_DATA.
  - Build the immediate: D-type sext(IR[20:12]); CB sext(IR[23:5]) << 2; B sext(IR[25:0]) << 2.
  - Unrecognised opcode -> HALT.
- Opcodes (from IR[31:21]):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx.
- EXEC:
  - ALU result = A op B (R-type) or A + imm (LDUR/STUR), modulo 2^DATA_W. Latch it.
  - B: PC <= PC + imm, RETIRE, go to FETCH.
  - CBZ/CBNZ: test B == 0 (or != 0). Taken: PC <= PC + imm, else PC + 4. RETIRE, go to FETCH.
  - Otherwise: R-type -> WB, LDUR/STUR -> MEM.
- MEM:
  - DMEM_REQ = 1, DMEM_ADDR = ALU result truncated to ADDR_W. For STUR, DMEM_WE = 1 and DMEM_WDATA = B. Hold until DMEM_VALID.
  - LDUR: latch DMEM_RDATA into MDR, go to WB.
  - STUR: PC += 4, RETIRE, go to FETCH.
- WB:
  - REGWRITE = 1 for one cycle, WRITE_REG = IR[4:0].
  - WRITE_REG_DATA = MDR for LDUR, else the ALU result.
  - Destination 31: REGWRITE is suppressed, but the instruction still retires.
  - PC += 4, RETIRE, go to FETCH.
- HALT: absorbing state. HALTED = 1, no requests, PC frozen. Exit only via RESET.
- Cycle counts with zero-wait memory (VALID high whenever REQ is high):
  - B/CBZ/CBNZ: 3. R-type and STUR: 4. LDUR: 5.
  - Each memory wait cycle adds 1.
- RETIRE_CNT increments with each RETIRE and wraps modulo 2^CNT_W.
- PC arithmetic is modulo 2^ADDR_W and wraps silently.
- All outputs are registered or decoded from state only; there is no combinational path from a VALID input to any REQ output.

Decomposition:
- Shared package legv8_pkg:
  - opcode constants.
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - ALU control codes: AND 0000, ORR 0001, ADD 0010, SUB 0110.
  - instruction-class enum: R, D_LD, D_ST, CB_Z, CB_NZ, B, ILL.
- Sub-module legv8_decode, purely combinational: takes IR, produces class, register indices, sign-extended/shifted immediate and ALU control. Reused later by the pipelined core.

Test Plan:
- Reset mid-MEM: hold DMEM_VALID = 0 during a STUR, assert RESET -> next cycle state = FETCH, PC = RESET_PC, DMEM_REQ = 0, RETIRE_CNT = 0.
- Zero-wait program, X1 = 7 and X2 = 5:
  - ADD X3,X1,X2 -> WRITE_REG 3, data 12, 4 cycles.
  - SUB X4,X1,X2 -> 2.
  - ORR X5 -> 7.
  - AND X6 -> 5.
  - RETIRE_CNT = 4 after 16 cycles.
- Load/store with X0 = 0x100:
  - STUR X1,[X0,#8] -> DMEM_ADDR 0x108, WE = 1, WDATA 7.
  - LDUR X9,[X0,#8] with RDATA 7 -> X9 = 7 in 5 cycles.
  - DMEM_VALID delayed 3 cycles -> LDUR takes 8 cycles and ADDR is stable throughout.
- Branches at PC 0x40:
  - CBZ X31,#-4 (imm19 = -1) -> PC = 0x3C.
  - CBNZ X31 -> PC = 0x44.
  - B imm26 = 0x3FFFFFF -> PC = 0x3C.
  - Each takes 3 cycles.
- XZR: ADD X31,X1,X2 -> REGWRITE stays 0, RETIRE pulses; a read of X31 with REG_DATA = 0xDEAD yields 0.
- Illegal word 0x00000000 -> HALTED = 1 after DECODE; no further IMEM_REQ or RETIRE; PC frozen until RESET.
